// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks in-flight GPR writes in the E, M and W stages of the 5-stage MIPS
//   core. Produces the pipeline stall request and the select codes for the
//   D-stage forwarding MUX4s and the E-stage ALU-operand MUX3s.
//
//   Optional build macro: HAZARD_STAT_EN
//     defined   -> stall_cnt counts stall cycles, saturating at all-ones.
//     undefined -> stall_cnt is tied to 0 and no counter register exists.
module hazard_scoreboard #(
   parameter int TW    = 2,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       d_rs,
   input  logic [4:0]       d_rt,
   input  logic [TW-1:0]    d_tuse_rs,
   input  logic [TW-1:0]    d_tuse_rt,
   input  logic             d_we,
   input  logic [4:0]       d_dst,
   input  logic [TW-1:0]    d_tnew,
   output logic             stall,
   output logic [1:0]       fwd_d_rs,
   output logic [1:0]       fwd_d_rt,
   output logic [1:0]       fwd_e_rs,
   output logic [1:0]       fwd_e_rt,
   output logic [CNT_W-1:0] stall_cnt
);

   // E keeps the operand addresses of the instruction it holds, because the
   // E-stage MUX3 selects are derived from them. Past E nothing reads the
   // operand addresses, so the M and W slots carry only the write record.
   typedef struct packed {
      logic          valid;
      logic [4:0]    dst;
      logic [TW-1:0] tnew;
      logic [4:0]    rs;
      logic [4:0]    rt;
   } e_slot_t;

   typedef struct packed {
      logic          valid;
      logic [4:0]    dst;
      logic [TW-1:0] tnew;
   } wr_slot_t;

   e_slot_t  e_q;
   wr_slot_t m_q;
   wr_slot_t w_q;

   e_slot_t  d_slot;
   wr_slot_t e_adv;
   wr_slot_t m_adv;

   logic stall_rs;
   logic stall_rt;

   // Saturating decrement: a result that already exists stays available.
   function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
      return (x == '0) ? '0 : x - TW'(1);
   endfunction

   // Register $0 is hard-wired to zero, so it never takes part in a hazard.
   function automatic logic hit(input logic v, input logic [4:0] dst,
                                input logic [4:0] a);
      return v && (a != 5'd0) && (dst == a);
   endfunction

   // Nearest producer (E, then M, then W) decides whether the operand is late.
   function automatic logic op_stall(input e_slot_t e, input wr_slot_t m,
                                     input wr_slot_t w, input logic [4:0] a,
                                     input logic [TW-1:0] tuse);
      if (hit(e.valid, e.dst, a))      return e.tnew > tuse;
      else if (hit(m.valid, m.dst, a)) return m.tnew > tuse;
      else if (hit(w.valid, w.dst, a)) return w.tnew > tuse;
      return 1'b0;
   endfunction

   // D-stage MUX4 select: 1=E, 2=M, 3=W, 0=register file. A nearer producer
   // whose result is not ready yet blocks older producers; E fixes it later.
   function automatic logic [1:0] d_sel(input e_slot_t e, input wr_slot_t m,
                                        input wr_slot_t w, input logic [4:0] a);
      if (hit(e.valid, e.dst, a))      return (e.tnew == '0) ? 2'd1 : 2'd0;
      else if (hit(m.valid, m.dst, a)) return (m.tnew == '0) ? 2'd2 : 2'd0;
      else if (hit(w.valid, w.dst, a)) return 2'd3;
      return 2'd0;
   endfunction

   // E-stage MUX3 select: 1=M, 2=W, 0=pipeline register value.
   function automatic logic [1:0] e_sel(input wr_slot_t m, input wr_slot_t w,
                                        input logic [4:0] a);
      if (hit(m.valid, m.dst, a))      return (m.tnew == '0) ? 2'd1 : 2'd0;
      else if (hit(w.valid, w.dst, a)) return 2'd2;
      return 2'd0;
   endfunction

   // Next-slot contents and all hazard outputs, combinational from slot state.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      stall    = 1'b0;
      fwd_d_rs = 2'd0;
      fwd_d_rt = 2'd0;
      fwd_e_rs = 2'd0;
      fwd_e_rt = 2'd0;

      d_slot       = '0;
      d_slot.valid = d_we && (d_dst != 5'd0);
      d_slot.dst   = d_dst;
      d_slot.tnew  = d_tnew;
      d_slot.rs    = d_rs;
      d_slot.rt    = d_rt;

      e_adv.valid = e_q.valid;
      e_adv.dst   = e_q.dst;
      e_adv.tnew  = sat_dec(e_q.tnew);

      m_adv       = m_q;
      m_adv.tnew  = sat_dec(m_q.tnew);

      stall_rs = op_stall(e_q, m_q, w_q, d_rs, d_tuse_rs);
      stall_rt = op_stall(e_q, m_q, w_q, d_rt, d_tuse_rt);

      // Reset overrides everything, so a stall seen in the reset cycle is
      // dropped and the pipeline restarts with no hazard outputs.
      if (!reset) begin
         stall    = stall_rs | stall_rt;
         fwd_d_rs = d_sel(e_q, m_q, w_q, d_rs);
         fwd_d_rt = d_sel(e_q, m_q, w_q, d_rt);
         fwd_e_rs = e_sel(m_q, w_q, e_q.rs);
         fwd_e_rt = e_sel(m_q, w_q, e_q.rt);
      end
   end

   // Slot pipeline: E takes D (or a bubble on stall); M and W always advance.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so E, M and W all
      // shift from their pre-edge values in the same clock.
      if (reset) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= stall ? e_slot_t'('0) : d_slot;
         m_q <= e_adv;
         w_q <= m_adv;
      end
   end

`ifdef HAZARD_STAT_EN
   logic [CNT_W-1:0] cnt_q;

   // Stall statistic: counts stall cycles, holds at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (stall && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule
